// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared status encoding and geometry for the SRAM request path.
// Revision : 1.0
// ============================================================================
package sram_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } sram_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sram_op_t;

    localparam int SRAM_DEPTH  = 1024;
    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 64;
    localparam int SRAM_CNT_W  = 4;

    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        return (addr < 32'(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_access_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_responder_if
// Purpose  : Request/status bundle between an SRAM initiator and the responder.
// Revision : 1.0
// ============================================================================
interface sram_access_responder_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    logic              sram_read_en;
    logic              sram_write_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;
    sram_state_t       sram_state;

    modport master (
        output sram_read_en,
        output sram_write_en,
        output sram_addr,
        output sram_write_data,
        input  sram_read_data,
        input  sram_state
    );

    modport slave (
        input  sram_read_en,
        input  sram_write_en,
        input  sram_addr,
        input  sram_write_data,
        output sram_read_data,
        output sram_state
    );

endinterface
`default_nettype wire

// File: rtl/sram_access_responder_storage_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_storage_array
// Purpose  : DEPTH x DATA_W single-port synchronous array, no reset on contents.
// Revision : 1.0
// ============================================================================
module sram_storage_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;

    assign w_idx = i_addr[IDX_W-1:0];

    // Address bits above the array index are screened out by the caller.
    generate
        if (IDX_W < ADDR_W) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^i_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_idx] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_responder
// Purpose  : SRAM-side responder with fixed multi-cycle latency and status.
// Revision : 1.0
// ============================================================================
module sram_access_responder
    import sram_pkg::*;
#(
    parameter int DEPTH   = SRAM_DEPTH,
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W,
    parameter int LATENCY = 2
) (
    input wire logic               clk,
    input wire logic               n_rst,
    sram_access_responder_if.slave bus
);

    localparam logic [SRAM_CNT_W-1:0] C_CNT_LOAD = SRAM_CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
            $error("sram_access_responder: LATENCY must be 1..15");
        end
    endgenerate

    sram_state_t             r_state;
    logic [SRAM_CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    sram_op_t                r_op;
    logic [DATA_W-1:0]       r_read_data;

    logic                    w_rd_req;
    logic                    w_wr_req;
    logic                    w_conflict;
    logic                    w_addr_ok;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_done;
    logic                    w_mem_we;
    logic                    w_mem_re;
    logic [ADDR_W-1:0]       w_mem_addr;
    logic [DATA_W-1:0]       w_mem_rdata;

    assign w_rd_req   = bus.sram_read_en  & ~bus.sram_write_en;
    assign w_wr_req   = bus.sram_write_en & ~bus.sram_read_en;
    assign w_conflict = bus.sram_read_en  &  bus.sram_write_en;
    assign w_addr_ok  = addr_legal(32'(bus.sram_addr), DEPTH);

    assign w_accept = (r_state == FREE) && (w_rd_req || w_wr_req) && w_addr_ok;
    assign w_reject = (r_state == FREE) && (w_conflict || ((w_rd_req || w_wr_req) && !w_addr_ok));
    assign w_done   = (r_state == BUSY) && (r_cnt == '0);

    // The array is fetched at acceptance so its registered output is settled
    // by the completion edge; nothing else can touch the array in between.
    assign w_mem_re   = w_accept && w_rd_req;
    assign w_mem_we   = w_done && (r_op == OP_WRITE);
    assign w_mem_addr = (r_state == FREE) ? bus.sram_addr : r_addr;

    sram_storage_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= FREE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= OP_READ;
            r_read_data <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_cnt   <= C_CNT_LOAD;
                        r_addr  <= bus.sram_addr;
                        r_wdata <= bus.sram_write_data;
                        r_op    <= w_wr_req ? OP_WRITE : OP_READ;
                    end else if (w_reject) begin
                        r_state <= ERROR;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state <= ACCESS;
                        if (r_op == OP_READ) begin
                            r_read_data <= w_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACCESS:  r_state <= FREE;
                ERROR:   r_state <= FREE;
                default: r_state <= FREE;
            endcase
        end
    end

    assign bus.sram_state     = r_state;
    assign bus.sram_read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_responder
// Purpose  : Scoreboard bench for two responder builds (default, and L=5/D=512).
// Revision : 1.0
// ============================================================================
module tb_sram_access_responder;
    import sram_pkg::*;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sram_access_responder_if #(.ADDR_W(10), .DATA_W(64)) bus_a ();
    sram_access_responder_if #(.ADDR_W(10), .DATA_W(64)) bus_b ();

    sram_access_responder #(.DEPTH(1024), .ADDR_W(10), .DATA_W(64), .LATENCY(2)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a.slave)
    );

    sram_access_responder #(.DEPTH(512), .ADDR_W(10), .DATA_W(64), .LATENCY(5)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [1:0]  state;
        logic [63:0] data;
        int          busy;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] model [int];
    logic [63:0] last_rd [2];
    int          checks   = 0;
    int          failures = 0;

    always @(posedge clk) begin
        if (n_rst) begin
            assert (!$isunknown({bus_a.sram_read_en, bus_a.sram_write_en,
                                 bus_b.sram_read_en, bus_b.sram_write_en}))
                else $error("request enable is X/Z");
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] state_of(input int d);
        return (d == 0) ? bus_a.sram_state : bus_b.sram_state;
    endfunction

    function automatic logic [63:0] rdata_of(input int d);
        return (d == 0) ? bus_a.sram_read_data : bus_b.sram_read_data;
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [9:0] addr, input logic [63:0] wd);
        if (d == 0) begin
            bus_a.sram_read_en = rd; bus_a.sram_write_en = wr;
            bus_a.sram_addr = addr;  bus_a.sram_write_data = wd;
        end else begin
            bus_b.sram_read_en = rd; bus_b.sram_write_en = wr;
            bus_b.sram_addr = addr;  bus_b.sram_write_data = wd;
        end
    endtask

    // One request: push the model's expectation, hold enables until the
    // terminal status, pop and compare, then confirm the return to FREE.
    task automatic run_req(input int d, input logic rd, input logic wr,
                           input logic [9:0] addr, input logic [63:0] wd,
                           input bit hold, input bit chg_addr, input logic [9:0] alt_addr);
        exp_t e;
        int   busy;
        bit   done;
        int   depth = (d == 0) ? 1024 : 512;
        int   lat   = (d == 0) ? 2 : 5;
        int   key   = d * 4096 + int'(addr);
        if ((rd && wr) || int'(addr) >= depth) begin
            e.state = ERROR; e.busy = 0; e.data = last_rd[d];
        end else begin
            e.state = ACCESS; e.busy = lat;
            if (rd) begin
                e.data     = model.exists(key) ? model[key] : 64'hx;
                last_rd[d] = e.data;
            end else begin
                model[key] = wd;
                e.data     = last_rd[d];
            end
        end
        sb_q.push_back(e);
        drive(d, rd, wr, addr, wd);
        busy = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            if (state_of(d) == BUSY) begin
                busy++;
                if (chg_addr && busy == 1) drive(d, rd, wr, alt_addr, ~wd);
            end else if (state_of(d) == ACCESS || state_of(d) == ERROR) begin
                done = 1'b1;
            end
        end
        check_val("terminal_seen", 64'(done), 64'd1);
        e = sb_q.pop_front();
        check_val("term_state", 64'(state_of(d)), 64'(e.state));
        check_val("busy_cycles", 64'(busy), 64'(e.busy));
        check_val("read_data", rdata_of(d), e.data);
        if (!hold) drive(d, 1'b0, 1'b0, addr, wd);
        @(posedge clk); #1;
        check_val("back_to_free", 64'(state_of(d)), 64'(FREE));
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 10'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 10'd0, 64'd0);
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("idle_state_a", 64'(state_of(0)), 64'(FREE));
            check_val("idle_rdata_a", rdata_of(0), 64'd0);
            check_val("idle_state_b", 64'(state_of(1)), 64'(FREE));
            check_val("idle_rdata_b", rdata_of(1), 64'd0);
        end

        run_req(0, 1'b0, 1'b1, 10'h007, 64'hAAAA_5555_1234_0F0F, 1'b0, 1'b0, 10'h0);
        run_req(0, 1'b0, 1'b1, 10'h005, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 10'h0);
        run_req(0, 1'b1, 1'b0, 10'h005, 64'h0,                   1'b0, 1'b0, 10'h0);
        run_req(0, 1'b1, 1'b1, 10'h007, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 10'h0);
        run_req(0, 1'b1, 1'b0, 10'h007, 64'h0,                   1'b0, 1'b0, 10'h0);

        run_req(0, 1'b0, 1'b1, 10'h002, 64'h2222_3333_4444_5555, 1'b0, 1'b0, 10'h0);
        run_req(0, 1'b0, 1'b1, 10'h3FF, 64'h9999_8888_7777_6666, 1'b0, 1'b0, 10'h0);
        run_req(0, 1'b1, 1'b0, 10'h002, 64'h0,                   1'b0, 1'b1, 10'h3FF);

        // Abort a write to addr 9 with reset while it is BUSY.
        run_req(0, 1'b0, 1'b1, 10'h009, 64'h1, 1'b0, 1'b0, 10'h0);
        drive(0, 1'b0, 1'b1, 10'h009, 64'hBAD0_BAD0_BAD0_BAD0);
        @(posedge clk); #1;
        check_val("busy_before_rst", 64'(state_of(0)), 64'(BUSY));
        #2 n_rst = 1'b0;
        #1;
        check_val("rst_state_a", 64'(state_of(0)), 64'(FREE));
        check_val("rst_rdata_a", rdata_of(0), 64'd0);
        check_val("rst_rdata_b", rdata_of(1), 64'd0);
        drive(0, 1'b0, 1'b0, 10'h009, 64'h0);
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        @(negedge clk);
        n_rst = 1'b1;
        run_req(0, 1'b1, 1'b0, 10'h009, 64'h0, 1'b0, 1'b0, 10'h0);

        run_req(1, 1'b0, 1'b1, 10'h000, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 10'h0);
        run_req(1, 1'b0, 1'b1, 10'h001, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 10'h0);
        run_req(1, 1'b1, 1'b0, 10'h000, 64'h0, 1'b1, 1'b0, 10'h0);
        run_req(1, 1'b1, 1'b0, 10'h001, 64'h0, 1'b0, 1'b0, 10'h0);
        run_req(1, 1'b1, 1'b0, 10'h200, 64'h0, 1'b0, 1'b0, 10'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
